// File: rtl/ring_decoder.sv
// ring_decoder: tracks a one-hot 8-bit ring counter, reporting position and direction.
// Optional step counter enabled by defining RING_STEP_CNT_EN.
module ring_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] ring,
    input  logic       clr_err,
    output logic       out_valid,
    output logic [2:0] idx,
    output logic       dir,
    output logic       locked,
    output logic       dir_chg,
    output logic       skip_err,
    output logic       err,
    output logic [7:0] step_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        LOCKED,
        FAULT
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [2:0] idx_nx;
    logic       dir_nx;
    logic       ov_nx;
    logic       dc_nx;
    logic       skip_nx;

    logic       legal;
    logic [2:0] pos;
    logic [2:0] up;
    logic [2:0] dn;
    logic [2:0] fwd;
    logic [2:0] rev;

    // legal means exactly one bit set
    assign legal = (ring != 8'h00) && ((ring & (ring - 8'h01)) == 8'h00);

    assign up  = idx + 3'd1;
    assign dn  = idx - 3'd1;
    assign fwd = dir ? dn : up;
    assign rev = dir ? up : dn;

    // binary position of the set bit (only meaningful when legal)
    always_comb begin
        pos = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (ring[i]) pos = i[2:0];
        end
    end

    // next-state and registered-output values
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        dir_nx   = dir;
        ov_nx    = 1'b0;
        dc_nx    = 1'b0;
        skip_nx  = skip_err;
        if (clr_err) begin
            skip_nx = 1'b0;
            if (state == FAULT) state_nx = IDLE;
        end else if (in_valid && state != FAULT) begin
            if (!legal) begin
                state_nx = FAULT;
            end else begin
                ov_nx  = 1'b1;
                idx_nx = pos;
                unique case (state)
                    IDLE: state_nx = SYNC;
                    SYNC: begin
                        if (pos == up) begin
                            dir_nx   = 1'b0;
                            state_nx = LOCKED;
                        end else if (pos == dn) begin
                            dir_nx   = 1'b1;
                            state_nx = LOCKED;
                        end
                    end
                    LOCKED: begin
                        unique case (1'b1)
                            (pos == idx): ;
                            (pos == fwd): ;
                            (pos == rev): begin
                                dir_nx = ~dir;
                                dc_nx  = 1'b1;
                            end
                            default: begin
                                skip_nx  = 1'b1;
                                state_nx = SYNC;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= 3'd0;
            dir       <= 1'b0;
            out_valid <= 1'b0;
            dir_chg   <= 1'b0;
            skip_err  <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            dir       <= dir_nx;
            out_valid <= ov_nx;
            dir_chg   <= dc_nx;
            skip_err  <= skip_nx;
        end
    end

    assign locked = (state == LOCKED);
    assign err    = (state == FAULT);

`ifdef RING_STEP_CNT_EN
    logic       step_inc;
    logic [7:0] cnt_q;

    assign step_inc = in_valid && !clr_err && legal
                      && state == LOCKED && pos == fwd;

    // saturating count of forward steps while locked
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= 8'd0;
        end else if (step_inc && cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign step_cnt = cnt_q;
`else
    assign step_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ring_decoder.sv
// tb_ring_decoder: directed and random stimulus against a behavioural model.
// Honours RING_STEP_CNT_EN for the step counter expectation.
module tb_ring_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] ring = 8'h00;
    logic       clr_err = 1'b0;
    logic       out_valid;
    logic [2:0] idx;
    logic       dir;
    logic       locked;
    logic       dir_chg;
    logic       skip_err;
    logic       err;
    logic [7:0] step_cnt;

    int checks = 0;
    int errors = 0;

    // model: state 0 idle, 1 sync, 2 locked, 3 fault
    int m_st = 0;
    int m_idx = 0;
    int m_dir = 0;
    int m_cnt = 0;
    int m_skip = 0;
    int m_ov = 0;
    int m_dc = 0;

    ring_decoder dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .ring     (ring),
        .clr_err  (clr_err),
        .out_valid(out_valid),
        .idx      (idx),
        .dir      (dir),
        .locked   (locked),
        .dir_chg  (dir_chg),
        .skip_err (skip_err),
        .err      (err),
        .step_cnt (step_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_cnt(input int c);
`ifdef RING_STEP_CNT_EN
        return c;
`else
        return 0;
`endif
    endfunction

    task automatic model(input bit r, input bit v, input bit c,
                         input logic [7:0] rg);
        int p;
        int f;
        int b;
        m_ov = 0;
        m_dc = 0;
        if (!r) begin
            m_st = 0; m_idx = 0; m_dir = 0;
            m_cnt = 0; m_skip = 0;
            return;
        end
        if (c) begin
            m_skip = 0;
            if (m_st == 3) m_st = 0;
            return;
        end
        if (!v || m_st == 3) return;
        if ($countones(rg) != 1) begin
            m_st = 3;
            return;
        end
        p = $clog2(rg);
        m_ov = 1;
        f = m_dir ? (m_idx + 7) % 8 : (m_idx + 1) % 8;
        b = m_dir ? (m_idx + 1) % 8 : (m_idx + 7) % 8;
        if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 1) begin
            if (p == (m_idx + 1) % 8) begin
                m_dir = 0; m_st = 2;
            end else if (p == (m_idx + 7) % 8) begin
                m_dir = 1; m_st = 2;
            end
        end else begin
            if (p == m_idx) begin
            end else if (p == f) begin
                if (m_cnt < 255) m_cnt++;
            end else if (p == b) begin
                m_dir = 1 - m_dir;
                m_dc = 1;
            end else begin
                m_skip = 1;
                m_st = 1;
            end
        end
        m_idx = p;
    endtask

    task automatic compare_all();
        check("out_valid", out_valid, m_ov);
        check("idx", idx, m_idx);
        check("dir", dir, m_dir);
        check("locked", locked, m_st == 2);
        check("dir_chg", dir_chg, m_dc);
        check("skip_err", skip_err, m_skip);
        check("err", err, m_st == 3);
        check("step_cnt", step_cnt, exp_cnt(m_cnt));
    endtask

    task automatic cyc(input bit r, input bit v, input bit c,
                       input logic [7:0] rg);
        @(negedge clk);
        rst = r;
        in_valid = v;
        clr_err = c;
        ring = rg;
        @(posedge clk);
        model(r, v, c, rg);
        #1;
        compare_all();
    endtask

    initial begin
        logic [7:0] rg;
        int sel;
        int k;

        // reset state
        cyc(0, 0, 0, 8'h00);
        check("rst_idx", idx, 0);
        check("rst_locked", locked, 0);
        check("rst_err", err, 0);
        check("rst_cnt", step_cnt, 0);

        // left lock sequence
        cyc(1, 1, 0, 8'h01);
        check("l_ov", out_valid, 1);
        cyc(1, 1, 0, 8'h02);
        check("l_locked2", locked, 1);
        cyc(1, 1, 0, 8'h04);
        cyc(1, 1, 0, 8'h08);
        check("l_dir", dir, 0);
        check("l_idx", idx, 3);
        check("l_cnt", step_cnt, exp_cnt(2));

        // reversal
        cyc(1, 1, 0, 8'h04);
        check("rv_dc", dir_chg, 1);
        check("rv_dir", dir, 1);
        check("rv_idx", idx, 2);
        check("rv_cnt", step_cnt, exp_cnt(2));
        cyc(1, 0, 0, 8'h00);
        check("rv_dc_pulse", dir_chg, 0);

        // skip from 0x04 to 0x40
        cyc(1, 1, 0, 8'h40);
        check("sk_err", skip_err, 1);
        check("sk_locked", locked, 0);
        check("sk_idx", idx, 6);

        // relock, fault, then clear with a dropped sample
        cyc(1, 1, 0, 8'h80);
        check("fl_locked", locked, 1);
        cyc(1, 1, 0, 8'h00);
        check("fl_err", err, 1);
        check("fl_idx", idx, 7);
        check("fl_ov", out_valid, 0);
        cyc(1, 1, 0, 8'h01);
        check("fl_ignore", idx, 7);
        cyc(1, 1, 1, 8'h01);
        check("fl_clr_err", err, 0);
        check("fl_clr_skip", skip_err, 0);
        check("fl_drop_ov", out_valid, 0);
        check("fl_drop_idx", idx, 7);
        cyc(1, 1, 0, 8'h01);
        check("fl_idle_load", idx, 0);
        check("fl_idle_unlk", locked, 0);

        // right lock with wrap
        cyc(0, 0, 0, 8'h00);
        cyc(1, 1, 0, 8'h02);
        cyc(1, 1, 0, 8'h01);
        cyc(1, 1, 0, 8'h80);
        cyc(1, 1, 0, 8'h40);
        check("r_dir", dir, 1);
        check("r_idx", idx, 6);
        check("r_skip", skip_err, 0);
        check("r_locked", locked, 1);

        // saturation over 300 forward steps
        cyc(0, 0, 0, 8'h00);
        for (int i = 0; i < 300; i++) begin
            rg = 8'h01 << (i % 8);
            cyc(1, 1, 0, rg);
        end
        check("sat_cnt", step_cnt, exp_cnt(255));
        cyc(0, 1, 0, 8'h08);
        check("mid_rst_idx", idx, 0);
        check("mid_rst_dir", dir, 0);
        check("mid_rst_lock", locked, 0);
        check("mid_rst_ov", out_valid, 0);
        check("mid_rst_cnt", step_cnt, 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 99);
            k = (sel < 35) ? 1 : (sel < 55) ? 7 : (sel < 65) ? 0 : 3;
            rg = 8'h01 << ((m_idx + k) % 8);
            if (sel >= 80) rg = 8'($urandom);
            cyc($urandom_range(0, 63) != 0,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 31) == 0,
                rg);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
